// File: rtl/zip_stream_fifo.sv
// Synchronous valid/ready FIFO that absorbs skid-buffer bursts and breaks the ready path.
// Optional zero-latency bypass when empty: define ZIP_STREAM_FIFO_BYPASS_EN.
module zip_stream_fifo #(
    parameter int unsigned DW           = 8,
    parameter int unsigned LGDEPTH      = 3,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DW-1:0]      i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DW-1:0]      o_data,
    output logic [LGDEPTH:0]   o_fill,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned PW = LGDEPTH + 1;
    localparam int unsigned D  = 1 << LGDEPTH;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]      mem_q [D];
    logic [LGDEPTH-1:0] wr_idx, rd_idx;
    logic               push, pop, bypass;
    logic [DW-1:0]      data_c;

    assign wr_idx = wr_ptr_q[LGDEPTH-1:0];
    assign rd_idx = rd_ptr_q[LGDEPTH-1:0];

    // Status derives from registered pointers only.
    assign o_fill  = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_fill == PW'(D));
    assign o_empty = (o_fill == PW'(0));
    assign o_ready = !o_full;

`ifdef ZIP_STREAM_FIFO_BYPASS_EN
    // An empty FIFO with a ready consumer hands the beat straight through.
    assign bypass  = o_empty && i_valid && i_ready;
    assign o_valid = !o_empty || i_valid;
`else
    assign bypass  = 1'b0;
    assign o_valid = !o_empty;
`endif

    assign push = i_valid && o_ready && !bypass;
    assign pop  = !o_empty && i_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Array is never cleared; reset only discards entries via the pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_idx] <= i_data;
        end
    end

    always_comb begin
        data_c = mem_q[rd_idx];
`ifdef ZIP_STREAM_FIFO_BYPASS_EN
        if (o_empty) begin
            data_c = i_data;
        end
`endif
        o_data = data_c;
        if (OPT_LOWPOWER && !o_valid) begin
            o_data = '0;
        end
    end

endmodule
